lc3_decode: RTL and testbench

LC3_DECODE -- requirements
Module: lc3_decode

---
 rtl/decode_pkg.sv | 41 ++++
 rtl/lc3_decode_ctrl.sv | 69 ++++++
 rtl/lc3_decode.sv | 102 ++++++++++
 tb/tb_lc3_decode.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared LC-3 decode types, field encodings and widths
package decode_pkg;

  typedef enum logic [3:0] {
    OP_BR   = 4'h0,
    OP_ADD  = 4'h1,
    OP_LD   = 4'h2,
    OP_ST   = 4'h3,
    OP_JSR  = 4'h4,
    OP_AND  = 4'h5,
    OP_LDR  = 4'h6,
    OP_STR  = 4'h7,
    OP_RTI  = 4'h8,
    OP_NOT  = 4'h9,
    OP_LDI  = 4'hA,
    OP_STI  = 4'hB,
    OP_JMP  = 4'hC,
    OP_RES  = 4'hD,
    OP_LEA  = 4'hE,
    OP_TRAP = 4'hF
  } opcode_e;

  localparam int ALU_W   = 2;
  localparam int PCS1_W  = 2;
  localparam int ECTRL_W = ALU_W + PCS1_W + 2;
  localparam int WCTRL_W = 2;

  localparam logic [ALU_W-1:0] ALU_ADD = 2'b00;
  localparam logic [ALU_W-1:0] ALU_AND = 2'b01;
  localparam logic [ALU_W-1:0] ALU_NOT = 2'b10;

  localparam logic [PCS1_W-1:0] PCS1_NONE = 2'b00;
  localparam logic [PCS1_W-1:0] PCS1_OFF9 = 2'b01;
  localparam logic [PCS1_W-1:0] PCS1_OFF6 = 2'b10;
  localparam logic [PCS1_W-1:0] PCS1_ZERO = 2'b11;

  localparam logic [WCTRL_W-1:0] WB_ALU = 2'd0;
  localparam logic [WCTRL_W-1:0] WB_MEM = 2'd1;
  localparam logic [WCTRL_W-1:0] WB_PC  = 2'd2;

endpackage

// File: rtl/lc3_decode_ctrl.sv
// rtl/lc3_decode_ctrl.sv - combinational opcode to execute/writeback/memory control map
import decode_pkg::*;

module lc3_decode_ctrl (
  input  logic [3:0]         opcode,
  input  logic               imm_flag,
  output logic [ECTRL_W-1:0] e_control,
  output logic [WCTRL_W-1:0] w_control,
  output logic               mem_control,
  output logic               illegal
);

  logic [ALU_W-1:0]  alu;
  logic [PCS1_W-1:0] pcs1;
  logic              pcs2;
  logic              op2;

  always_comb begin
    alu         = ALU_ADD;
    pcs1        = PCS1_NONE;
    pcs2        = 1'b0;
    op2         = 1'b0;
    w_control   = WB_ALU;
    mem_control = 1'b0;
    illegal     = 1'b0;
    case (opcode_e'(opcode))
      OP_ADD: op2 = ~imm_flag;
      OP_AND: begin
        alu = ALU_AND;
        op2 = ~imm_flag;
      end
      OP_NOT: alu = ALU_NOT;
      OP_BR, OP_ST: begin
        pcs1 = PCS1_OFF9;
        pcs2 = 1'b1;
      end
      OP_LD: begin
        pcs1      = PCS1_OFF9;
        pcs2      = 1'b1;
        w_control = WB_MEM;
      end
      OP_LDI: begin
        pcs1        = PCS1_OFF9;
        pcs2        = 1'b1;
        w_control   = WB_MEM;
        mem_control = 1'b1;
      end
      OP_STI: begin
        pcs1        = PCS1_OFF9;
        pcs2        = 1'b1;
        mem_control = 1'b1;
      end
      OP_LEA: begin
        pcs1      = PCS1_OFF9;
        pcs2      = 1'b1;
        w_control = WB_PC;
      end
      OP_LDR: begin
        pcs1      = PCS1_OFF6;
        w_control = WB_MEM;
      end
      OP_STR: pcs1 = PCS1_OFF6;
      OP_JMP: pcs1 = PCS1_ZERO;
      default: illegal = 1'b1;
    endcase
    e_control = {alu, pcs1, pcs2, op2};
  end

endmodule

// File: rtl/lc3_decode.sv
// rtl/lc3_decode.sv - LC-3 decode stage registers; DECODE_PERF_CNT_EN adds a saturating legal-instruction counter
import decode_pkg::*;

module lc3_decode (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable_decode,
  input  logic [15:0]        dout,
  input  logic [15:0]        npc_in,
  output logic [15:0]        IR,
  output logic [15:0]        npc_out,
  output logic [ECTRL_W-1:0] E_Control,
  output logic [WCTRL_W-1:0] W_Control,
  output logic               Mem_Control,
  output logic               illegal_op,
  output logic [15:0]        instr_count
);

  logic [ECTRL_W-1:0] e_dec;
  logic [WCTRL_W-1:0] w_dec;
  logic               mem_dec;
  logic               ill_dec;

  lc3_decode_ctrl u_ctrl (
    .opcode      (dout[15:12]),
    .imm_flag    (dout[5]),
    .e_control   (e_dec),
    .w_control   (w_dec),
    .mem_control (mem_dec),
    .illegal     (ill_dec)
  );

  logic [15:0]        ir_q, ir_d;
  logic [15:0]        npc_q, npc_d;
  logic [ECTRL_W-1:0] e_ctrl_q, e_ctrl_d;
  logic [WCTRL_W-1:0] w_ctrl_q, w_ctrl_d;
  logic               mem_ctrl_q, mem_ctrl_d;
  logic               illegal_q, illegal_d;

  always_comb begin
    ir_d       = ir_q;
    npc_d      = npc_q;
    e_ctrl_d   = e_ctrl_q;
    w_ctrl_d   = w_ctrl_q;
    mem_ctrl_d = mem_ctrl_q;
    illegal_d  = illegal_q;
    if (enable_decode) begin
      ir_d       = dout;
      npc_d      = npc_in;
      e_ctrl_d   = e_dec;
      w_ctrl_d   = w_dec;
      mem_ctrl_d = mem_dec;
      illegal_d  = ill_dec;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ir_q       <= '0;
      npc_q      <= '0;
      e_ctrl_q   <= '0;
      w_ctrl_q   <= '0;
      mem_ctrl_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      ir_q       <= ir_d;
      npc_q      <= npc_d;
      e_ctrl_q   <= e_ctrl_d;
      w_ctrl_q   <= w_ctrl_d;
      mem_ctrl_q <= mem_ctrl_d;
      illegal_q  <= illegal_d;
    end
  end

`ifdef DECODE_PERF_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Saturates rather than wraps so a long run never reports a small count.
  always_comb begin
    cnt_d = cnt_q;
    if (enable_decode && !ill_dec && cnt_q != 16'hFFFF)
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign instr_count = cnt_q;
`else
  assign instr_count = 16'd0;
`endif

  assign IR          = ir_q;
  assign npc_out     = npc_q;
  assign E_Control   = e_ctrl_q;
  assign W_Control   = w_ctrl_q;
  assign Mem_Control = mem_ctrl_q;
  assign illegal_op  = illegal_q;

endmodule

// File: tb/tb_lc3_decode.sv
// tb/tb_lc3_decode.sv - randomized self-checking bench for lc3_decode against a table-driven model
module tb_lc3_decode;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable_decode = 1'b0;
  logic [15:0] dout = '0;
  logic [15:0] npc_in = '0;
  logic [15:0] IR, npc_out, instr_count;
  logic [5:0]  E_Control;
  logic [1:0]  W_Control;
  logic        Mem_Control, illegal_op;

  lc3_decode dut (
    .clock         (clock),
    .reset         (reset),
    .enable_decode (enable_decode),
    .dout          (dout),
    .npc_in        (npc_in),
    .IR            (IR),
    .npc_out       (npc_out),
    .E_Control     (E_Control),
    .W_Control     (W_Control),
    .Mem_Control   (Mem_Control),
    .illegal_op    (illegal_op),
    .instr_count   (instr_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fails  = 0;

  // Spec decode table indexed by opcode nibble; ADD/AND get op2select from ~IR[5] separately.
  logic [5:0] tab_e   [16];
  logic [1:0] tab_w   [16];
  logic       tab_m   [16];
  logic       tab_ill [16];

  logic [15:0] m_ir, m_npc, m_cnt;
  logic [5:0]  m_e;
  logic [1:0]  m_w;
  logic        m_m, m_ill;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".ir"},  IR, m_ir);
    check_eq({tag, ".npc"}, npc_out, m_npc);
    check_eq({tag, ".e"},   16'(E_Control), 16'(m_e));
    check_eq({tag, ".w"},   16'(W_Control), 16'(m_w));
    check_eq({tag, ".m"},   16'(Mem_Control), 16'(m_m));
    check_eq({tag, ".ill"}, 16'(illegal_op), 16'(m_ill));
    check_eq({tag, ".cnt"}, instr_count, m_cnt);
  endtask

  task automatic model_reset();
    m_ir = '0; m_npc = '0; m_e = '0; m_w = '0; m_m = 1'b0; m_ill = 1'b0; m_cnt = '0;
  endtask

  task automatic model_capture(input logic [15:0] d, input logic [15:0] n);
    int op;
    op    = int'(d[15:12]);
    m_ir  = d;
    m_npc = n;
    m_ill = tab_ill[op];
    m_e   = tab_e[op];
    m_w   = tab_w[op];
    m_m   = tab_m[op];
    if (op == 1 || op == 5) m_e[0] = ~d[5];
`ifdef DECODE_PERF_CNT_EN
    if (!m_ill && m_cnt < 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
  endtask

  task automatic cap(input logic en, input logic [15:0] d, input logic [15:0] n);
    @(negedge clock);
    enable_decode = en;
    dout          = d;
    npc_in        = n;
    @(posedge clock);
    if (reset && en) model_capture(d, n);
    #1;
  endtask

  function automatic logic [15:0] rand_legal();
    logic [15:0] w;
    w = 16'($urandom);
    if (w[15:12] == 4'h4 || w[15:12] == 4'h8 || w[15:12] == 4'hD || w[15:12] == 4'hF)
      w[15:12] = 4'h1;
    return w;
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) begin
      tab_e[i] = '0; tab_w[i] = '0; tab_m[i] = 1'b0; tab_ill[i] = 1'b0;
    end
    tab_e[4'h5] = 6'b010000;
    tab_e[4'h9] = 6'b100000;
    tab_e[4'h0] = 6'b000110;
    tab_e[4'h2] = 6'b000110; tab_w[4'h2] = 2'd1;
    tab_e[4'h3] = 6'b000110;
    tab_e[4'hA] = 6'b000110; tab_w[4'hA] = 2'd1; tab_m[4'hA] = 1'b1;
    tab_e[4'hB] = 6'b000110; tab_m[4'hB] = 1'b1;
    tab_e[4'hE] = 6'b000110; tab_w[4'hE] = 2'd2;
    tab_e[4'h6] = 6'b001000; tab_w[4'h6] = 2'd1;
    tab_e[4'h7] = 6'b001000;
    tab_e[4'hC] = 6'b001100;
    tab_ill[4'h4] = 1'b1; tab_ill[4'h8] = 1'b1; tab_ill[4'hD] = 1'b1; tab_ill[4'hF] = 1'b1;
    model_reset();

    #12;
    check_all("reset");
    @(negedge clock);
    reset = 1'b1;

    cap(1'b1, 16'h1283, 16'h3001);
    check_all("add_reg");
    check_eq("add_reg.e_lit", 16'(E_Control), 16'h0001);

    cap(1'b1, 16'hA005, 16'h3002);
    check_all("ldi");
    check_eq("ldi.w_lit", 16'(W_Control), 16'd1);
    cap(1'b1, 16'hE003, 16'h3003);
    check_all("lea");
    check_eq("lea.w_lit", 16'(W_Control), 16'd2);

    cap(1'b1, 16'h5020, 16'h3004);
    check_all("and_imm");
    for (int i = 0; i < 3; i++) begin
      cap(1'b0, 16'h9FFF, 16'hBEEF);
      check_all("stall");
      check_eq("stall.ir_lit", IR, 16'h5020);
    end

    cap(1'b1, 16'hF025, 16'h3005);
    check_all("illegal");
    check_eq("illegal.flag_lit", 16'(illegal_op), 16'd1);
    cap(1'b1, 16'hC1C0, 16'h3006);
    check_all("jmp_after_illegal");
    check_eq("jmp.e_lit", 16'(E_Control), 16'h000C);

    // Async reset between edges, mid-stall, held across an enabled edge.
    cap(1'b1, 16'h6A3F, 16'h4000);
    cap(1'b0, 16'h1111, 16'h2222);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    enable_decode = 1'b1;
    dout          = 16'h1234;
    @(posedge clock);
    #1;
    check_all("reset_over_enable");
    @(negedge clock);
    reset = 1'b1;
    cap(1'b1, 16'h1023, 16'h5000);
    check_all("post_reset");

    for (int i = 0; i < 1500; i++) begin
      cap(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom));
      check_all("rand");
    end

    // Fresh counter: 65535 legal captures reach the ceiling, two more must hold it.
    @(negedge clock);
    reset = 1'b0;
    #1;
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 65535; i++) cap(1'b1, rand_legal(), 16'($urandom));
    check_all("sat_reach");
`ifdef DECODE_PERF_CNT_EN
    check_eq("sat_reach.lit", instr_count, 16'hFFFF);
`else
    check_eq("no_cnt.lit", instr_count, 16'h0000);
`endif
    cap(1'b1, rand_legal(), 16'h0001);
    cap(1'b1, rand_legal(), 16'h0002);
    check_all("sat_hold");
    cap(1'b1, 16'hD000, 16'h0003);
    check_all("sat_illegal");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
